// File: rtl/tick_scheduler.sv
// Multi-channel tick-enable scheduler: shared prescaler, per-channel period down-counters and a
// two-state valid/ready config port. Define TICK_SCHED_SQUARE_EN to add per-channel sq outputs.
module tick_scheduler #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_W     = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned PRE_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_en,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
`ifdef TICK_SCHED_SQUARE_EN
  output logic [NUM_CH-1:0] sq,
`endif
  output logic [NUM_CH-1:0] active
);

  localparam logic [PRE_W-1:0] PreMax = PRE_W'(PRESCALE - 1);
  localparam logic [CH_W:0]    NumChW = (CH_W + 1)'(NUM_CH);

  typedef enum logic {StIdle, StApply} cfg_state_e;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             base_tick;

  cfg_state_e       state_q, state_d;
  logic [CH_W-1:0]  lat_ch_q, lat_ch_d;
  logic [CNT_W-1:0] lat_period_q, lat_period_d;
  logic             lat_en_q, lat_en_d;
  logic             cfg_err_q, cfg_err_d;
  logic             accept;

  logic [NUM_CH-1:0] ch_run_q, ch_run_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  per_q [NUM_CH];
  logic [CNT_W-1:0]  per_d [NUM_CH];
`ifdef TICK_SCHED_SQUARE_EN
  logic [NUM_CH-1:0] sq_q, sq_d;
`endif

  // Prescaler: base_tick marks the last cycle of each PRESCALE window.
  assign base_tick = run && (pre_cnt_q == PreMax);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (run) begin
      pre_cnt_d = base_tick ? '0 : pre_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_ch_d     = lat_ch_q;
    lat_period_d = lat_period_q;
    lat_en_d     = lat_en_q;
    cfg_err_d    = 1'b0;
    cfg_ready    = (state_q == StIdle);
    accept       = cfg_valid && cfg_ready;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          lat_ch_d     = cfg_ch;
          lat_period_d = cfg_period;
          lat_en_d     = cfg_en;
          cfg_err_d    = ({1'b0, cfg_ch} >= NumChW);
          state_d      = StApply;
        end
      end
      StApply: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // An out-of-range lat_ch_q never matches a channel index, so invalid writes change nothing.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ch_run_d[i] = ch_run_q[i];
      cnt_d[i]    = cnt_q[i];
      per_d[i]    = per_q[i];
      tick_d[i]   = 1'b0;
`ifdef TICK_SCHED_SQUARE_EN
      sq_d[i]     = sq_q[i];
`endif
      if ((state_q == StApply) && (lat_ch_q == CH_W'(i))) begin
`ifdef TICK_SCHED_SQUARE_EN
        sq_d[i] = 1'b0;
`endif
        if (lat_en_q && (lat_period_q != '0)) begin
          ch_run_d[i] = 1'b1;
          cnt_d[i]    = lat_period_q - 1'b1;
          per_d[i]    = lat_period_q;
        end else begin
          ch_run_d[i] = 1'b0;
          cnt_d[i]    = '0;
        end
      end else if (ch_run_q[i] && base_tick) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i]  = per_q[i] - 1'b1;
          tick_d[i] = 1'b1;
`ifdef TICK_SCHED_SQUARE_EN
          sq_d[i]   = ~sq_q[i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q    <= '0;
      state_q      <= StIdle;
      lat_ch_q     <= '0;
      lat_period_q <= '0;
      lat_en_q     <= 1'b0;
      cfg_err_q    <= 1'b0;
      ch_run_q     <= '0;
      tick_q       <= '0;
      cnt_q        <= '{default: '0};
      per_q        <= '{default: '0};
`ifdef TICK_SCHED_SQUARE_EN
      sq_q         <= '0;
`endif
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      state_q      <= state_d;
      lat_ch_q     <= lat_ch_d;
      lat_period_q <= lat_period_d;
      lat_en_q     <= lat_en_d;
      cfg_err_q    <= cfg_err_d;
      ch_run_q     <= ch_run_d;
      tick_q       <= tick_d;
      cnt_q        <= cnt_d;
      per_q        <= per_d;
`ifdef TICK_SCHED_SQUARE_EN
      sq_q         <= sq_d;
`endif
    end
  end

  assign tick    = tick_q;
  assign active  = ch_run_q;
  assign cfg_err = cfg_err_q;
`ifdef TICK_SCHED_SQUARE_EN
  assign sq      = sq_q;
`endif

endmodule
